if_fetch_unit: RTL

//  Instruction-fetch engine: the producer side of the IF->ID pipeline register. It owns the PC and

---
 rtl/if_fetch_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch engine feeding the IF/ID register: owns the PC, runs req/ack fetches,
// honours Freeze via a one-entry skid buffer and squashes wrong-path words on branch redirects.
module if_fetch_unit #(
  parameter int unsigned           WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WORD_WIDTH-1:0] PC_STEP    = WORD_WIDTH'(3'd4)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Freeze,
  input  logic                  Branch_taken,
  input  logic [WORD_WIDTH-1:0] Branch_addr,
  output logic                  imem_req,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [WORD_WIDTH-1:0] imem_rdata,
  output logic [WORD_WIDTH-1:0] PC_out,
  output logic [WORD_WIDTH-1:0] instruction_out,
  output logic                  instr_valid
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SKID  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [WORD_WIDTH-1:0] ALIGN_MASK = ~(WORD_WIDTH'(2'b11));

  state_t                  state_r, state_s;
  logic [WORD_WIDTH-1:0]   pc_r, pc_s;
  logic                    req_r, req_s;
  logic [WORD_WIDTH-1:0]   addr_r, addr_s;
  logic [WORD_WIDTH-1:0]   pc_out_r, pc_out_s;
  logic [WORD_WIDTH-1:0]   instr_r, instr_s;
  logic                    valid_r, valid_s;
  logic [WORD_WIDTH-1:0]   skid_data_r, skid_data_s;
  logic [WORD_WIDTH-1:0]   skid_pc_r, skid_pc_s;
  logic [WORD_WIDTH-1:0]   pc_inc_s;
  logic                    slot_free_s;

  assign pc_inc_s    = pc_r + PC_STEP;
  assign slot_free_s = ~valid_r | ~Freeze;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      pc_r        <= RESET_PC & ALIGN_MASK;
      req_r       <= 1'b0;
      addr_r      <= '0;
      pc_out_r    <= '0;
      instr_r     <= '0;
      valid_r     <= 1'b0;
      skid_data_r <= '0;
      skid_pc_r   <= '0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      req_r       <= req_s;
      addr_r      <= addr_s;
      pc_out_r    <= pc_out_s;
      instr_r     <= instr_s;
      valid_r     <= valid_s;
      skid_data_r <= skid_data_s;
      skid_pc_r   <= skid_pc_s;
    end
  end

  // Next-state selection; a redirect drains an unacknowledged request before refetching
  always_comb begin
    state_s = state_r;
    if (Branch_taken) begin
      if (((state_r == ST_REQ) || (state_r == ST_DRAIN)) && !imem_ack) begin
        state_s = ST_DRAIN;
      end else begin
        state_s = ST_REQ;
      end
    end else begin
      case (state_r)
        ST_IDLE:  state_s = ST_REQ;
        ST_REQ: begin
          if (imem_ack && !slot_free_s) begin
            state_s = ST_SKID;
          end else begin
            state_s = ST_REQ;
          end
        end
        ST_SKID: begin
          if (!Freeze) begin
            state_s = ST_REQ;
          end else begin
            state_s = ST_SKID;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            state_s = ST_REQ;
          end else begin
            state_s = ST_DRAIN;
          end
        end
        default:  state_s = ST_IDLE;
      endcase
    end
  end

  // Next PC, presented word, skid contents and request lines
  always_comb begin
    pc_s        = pc_r;
    skid_data_s = skid_data_r;
    skid_pc_s   = skid_pc_r;
    // An unfrozen edge consumes the presented word; unless replaced below it becomes a bubble
    if (!Freeze) begin
      pc_out_s = '0;
      instr_s  = '0;
      valid_s  = 1'b0;
    end else begin
      pc_out_s = pc_out_r;
      instr_s  = instr_r;
      valid_s  = valid_r;
    end

    if (Branch_taken) begin
      pc_s        = Branch_addr & ALIGN_MASK;
      pc_out_s    = '0;
      instr_s     = '0;
      valid_s     = 1'b0;
      skid_data_s = '0;
      skid_pc_s   = '0;
    end else begin
      case (state_r)
        ST_REQ: begin
          if (imem_ack) begin
            pc_s = pc_inc_s;
            if (slot_free_s) begin
              pc_out_s = pc_inc_s;
              instr_s  = imem_rdata;
              valid_s  = 1'b1;
            end else begin
              skid_data_s = imem_rdata;
              skid_pc_s   = pc_inc_s;
            end
          end else begin
            pc_s = pc_r;
          end
        end
        ST_SKID: begin
          if (!Freeze) begin
            pc_out_s = skid_pc_r;
            instr_s  = skid_data_r;
            valid_s  = 1'b1;
          end else begin
            valid_s = valid_r;
          end
        end
        ST_IDLE, ST_DRAIN: pc_s = pc_r;
        default:           pc_s = pc_r;
      endcase
    end

    // A drained request keeps its abandoned address until the ack arrives
    req_s = (state_s == ST_REQ) || (state_s == ST_DRAIN);
    if (state_s == ST_REQ) begin
      addr_s = pc_s & ALIGN_MASK;
    end else begin
      addr_s = addr_r;
    end
  end

  assign imem_req        = req_r;
  assign imem_addr       = addr_r;
  assign PC_out          = pc_out_r;
  assign instruction_out = instr_r;
  assign instr_valid     = valid_r;

endmodule
